// File: rtl/vx_mem_tag_remap.sv
// Remaps wide GPU memory tags onto a small out-of-order ID pool and restores them on read responses.
// Latency: one register stage on the request path and one on the response path (1 cycle each).
// Backpressure: requests stall on a held output register or, for reads only, when every ID is in flight.
module vx_mem_tag_remap #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 512,
    parameter int TAG_WIDTH  = 12,
    parameter int NUM_IDS    = 16,
    localparam int ID_WIDTH  = $clog2(NUM_IDS),
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // GPU-side request
    input  logic                  in_req_valid,
    input  logic                  in_req_rw,
    input  logic [BE_WIDTH-1:0]   in_req_byteen,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [DATA_WIDTH-1:0] in_req_data,
    input  logic [TAG_WIDTH-1:0]  in_req_tag,
    output logic                  in_req_ready,
    // GPU-side response
    output logic                  in_rsp_valid,
    output logic [DATA_WIDTH-1:0] in_rsp_data,
    output logic [TAG_WIDTH-1:0]  in_rsp_tag,
    input  logic                  in_rsp_ready,
    // Controller-side request
    output logic                  out_req_valid,
    output logic                  out_req_rw,
    output logic [BE_WIDTH-1:0]   out_req_byteen,
    output logic [ADDR_WIDTH-1:0] out_req_addr,
    output logic [DATA_WIDTH-1:0] out_req_data,
    output logic [ID_WIDTH-1:0]   out_req_tag,
    input  logic                  out_req_ready,
    // Controller-side response
    input  logic                  out_rsp_valid,
    input  logic [DATA_WIDTH-1:0] out_rsp_data,
    input  logic [ID_WIDTH-1:0]   out_rsp_tag,
    output logic                  out_rsp_ready,
    // Status
    output logic [ID_WIDTH:0]     pending_count,
    output logic                  tag_error
);

    localparam logic [ID_WIDTH:0] CNT_ONE = 1;

    // ID bookkeeping
    logic [NUM_IDS-1:0]   free_q, free_d;
    logic [ID_WIDTH:0]    cnt_q, cnt_d;
    logic                 tag_err_q, tag_err_d;
    logic [TAG_WIDTH-1:0] tag_tbl_q [NUM_IDS];

    // Request output register
    logic                  oreq_vld_q, oreq_vld_d;
    logic                  oreq_rw_q, oreq_rw_d;
    logic [BE_WIDTH-1:0]   oreq_be_q, oreq_be_d;
    logic [ADDR_WIDTH-1:0] oreq_addr_q, oreq_addr_d;
    logic [DATA_WIDTH-1:0] oreq_data_q, oreq_data_d;
    logic [ID_WIDTH-1:0]   oreq_tag_q, oreq_tag_d;

    // Response output register
    logic                  irsp_vld_q, irsp_vld_d;
    logic [DATA_WIDTH-1:0] irsp_data_q, irsp_data_d;
    logic [TAG_WIDTH-1:0]  irsp_tag_q, irsp_tag_d;

    logic [ID_WIDTH-1:0] alloc_id;
    logic                any_free;
    logic                req_fire;
    logic                rd_alloc;
    logic                rsp_fire;
    logic                rsp_good;
    logic                rsp_bad;

    // Lowest-index free ID; scanning downward lets the lowest set bit win.
    always_comb begin
        alloc_id = '0;
        any_free = |free_q;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_id = ID_WIDTH'(i);
            end
        end
    end

    // Handshakes: reads additionally need a free ID, writes never consume one.
    always_comb begin
        in_req_ready  = (!oreq_vld_q || out_req_ready) && (in_req_rw || any_free);
        req_fire      = in_req_valid && in_req_ready;
        rd_alloc      = req_fire && !in_req_rw;
        out_rsp_ready = !irsp_vld_q || in_rsp_ready;
        rsp_fire      = out_rsp_valid && out_rsp_ready;
        // A response for an ID that is already free is spurious and gets dropped.
        rsp_bad       = rsp_fire && free_q[out_rsp_tag];
        rsp_good      = rsp_fire && !free_q[out_rsp_tag];
    end

    // Free mask, outstanding counter and sticky error next state.
    always_comb begin
        free_d = free_q;
        if (rd_alloc) begin
            free_d[alloc_id] = 1'b0;
        end
        // The freed ID was allocated, the allocated one was free: never the same bit.
        if (rsp_good) begin
            free_d[out_rsp_tag] = 1'b1;
        end
        cnt_d = cnt_q;
        if (rd_alloc && !rsp_good) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!rd_alloc && rsp_good) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        tag_err_d = tag_err_q || rsp_bad;
    end

    // Request register: load on accept, hold while the controller stalls.
    always_comb begin
        oreq_vld_d  = oreq_vld_q;
        oreq_rw_d   = oreq_rw_q;
        oreq_be_d   = oreq_be_q;
        oreq_addr_d = oreq_addr_q;
        oreq_data_d = oreq_data_q;
        oreq_tag_d  = oreq_tag_q;
        if (!oreq_vld_q || out_req_ready) begin
            oreq_vld_d = req_fire;
        end
        if (req_fire) begin
            oreq_rw_d   = in_req_rw;
            oreq_be_d   = in_req_byteen;
            oreq_addr_d = in_req_addr;
            oreq_data_d = in_req_data;
            oreq_tag_d  = in_req_rw ? '0 : alloc_id;
        end
    end

    // Response register: capture a valid beat with its restored tag, hold while the GPU stalls.
    always_comb begin
        irsp_vld_d  = irsp_vld_q && !in_rsp_ready;
        irsp_data_d = irsp_data_q;
        irsp_tag_d  = irsp_tag_q;
        if (rsp_good) begin
            irsp_vld_d  = 1'b1;
            irsp_data_d = out_rsp_data;
            irsp_tag_d  = tag_tbl_q[out_rsp_tag];
        end
    end

    // State registers; a reset drops every in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_q      <= '1;
            cnt_q       <= '0;
            tag_err_q   <= 1'b0;
            oreq_vld_q  <= 1'b0;
            oreq_rw_q   <= 1'b0;
            oreq_be_q   <= '0;
            oreq_addr_q <= '0;
            oreq_data_q <= '0;
            oreq_tag_q  <= '0;
            irsp_vld_q  <= 1'b0;
            irsp_data_q <= '0;
            irsp_tag_q  <= '0;
        end else begin
            free_q      <= free_d;
            cnt_q       <= cnt_d;
            tag_err_q   <= tag_err_d;
            oreq_vld_q  <= oreq_vld_d;
            oreq_rw_q   <= oreq_rw_d;
            oreq_be_q   <= oreq_be_d;
            oreq_addr_q <= oreq_addr_d;
            oreq_data_q <= oreq_data_d;
            oreq_tag_q  <= oreq_tag_d;
            irsp_vld_q  <= irsp_vld_d;
            irsp_data_q <= irsp_data_d;
            irsp_tag_q  <= irsp_tag_d;
        end
    end

    // Tag table: contents only matter while the ID is allocated, so no reset.
    always_ff @(posedge clk) begin
        if (rd_alloc) begin
            tag_tbl_q[alloc_id] <= in_req_tag;
        end
    end

    assign out_req_valid  = oreq_vld_q;
    assign out_req_rw     = oreq_rw_q;
    assign out_req_byteen = oreq_be_q;
    assign out_req_addr   = oreq_addr_q;
    assign out_req_data   = oreq_data_q;
    assign out_req_tag    = oreq_tag_q;
    assign in_rsp_valid   = irsp_vld_q;
    assign in_rsp_data    = irsp_data_q;
    assign in_rsp_tag     = irsp_tag_q;
    assign pending_count  = cnt_q;
    assign tag_error      = tag_err_q;

endmodule
